// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_array_mult_if.sv
// Operand/product handshake bundle for seq_array_mult.
interface seq_array_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               busy;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pp_row_adder.sv
// WIDTH-bit ripple adder for one partial-product row, built from full_adder cells.
module pp_row_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];
endmodule

// File: rtl/seq_array_mult.sv
// Sequential shift-and-add multiplier: one partial-product row per clock, signed or unsigned.
module seq_array_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  seq_array_mult_if.slave bus
);
  localparam int unsigned CW  = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned MSB = WIDTH - 1;

  state_t state, state_next;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic [PW-1:0]    out_p;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] row_sum;
  logic             row_carry;
  logic [WIDTH-1:0] acc_hi_next;
  logic [WIDTH-1:0] acc_lo_next;
  logic [PW-1:0]    raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = BUSY;
      end
      BUSY: begin
        bus.busy = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (state == BUSY) && (cnt == '0);

  // Signed operands are stored as magnitudes; the most negative value maps to 2^(WIDTH-1).
  assign abs_a = (bus.in_signed && bus.in_a[MSB]) ? (~bus.in_a + WIDTH'(1)) : bus.in_a;
  assign abs_b = (bus.in_signed && bus.in_b[MSB]) ? (~bus.in_b + WIDTH'(1)) : bus.in_b;

  assign addend = mplr[0] ? mcand : '0;

  pp_row_adder #(.WIDTH(WIDTH)) u_row (
    .a    (acc_hi),
    .b    (addend),
    .sum  (row_sum),
    .cout (row_carry)
  );

  // The row carry is shifted straight into acc_hi, so acc_hi needs no stored carry bit.
  assign acc_hi_next = {row_carry, row_sum[WIDTH-1:1]};
  assign acc_lo_next = {row_sum[0], acc_lo[WIDTH-1:1]};
  assign raw         = {acc_hi_next, acc_lo_next};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplr   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      out_p  <= '0;
    end else if (accept) begin
      mcand  <= abs_a;
      mplr   <= abs_b;
      neg    <= bus.in_signed & (bus.in_a[MSB] ^ bus.in_b[MSB]);
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= CW'(WIDTH - 1);
    end else if (state == BUSY) begin
      acc_hi <= acc_hi_next;
      acc_lo <= acc_lo_next;
      mplr   <= mplr >> 1;
      if (cnt != '0) cnt <= cnt - CW'(1);
      if (last) out_p <= neg ? (~raw + PW'(1)) : raw;
    end
  end

  assign bus.out_p = out_p;

endmodule

// File: tb/tb_seq_array_mult.sv
// Scoreboard bench for seq_array_mult at WIDTH=8 and WIDTH=4 against an integer reference model.
module tb_seq_array_mult;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  seq_array_mult_if #(.WIDTH(8)) b8 ();
  seq_array_mult_if #(.WIDTH(4)) b4 ();

  seq_array_mult #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  seq_array_mult #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  // Reference: interpret operands per mode, multiply as integers, keep 2*w bits.
  function automatic logic [63:0] ref_mult(int w, logic [63:0] a, logic [63:0] b, bit sgn);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Scoreboard state per DUT
  logic [63:0] q8[$];
  logic [63:0] q4[$];
  int unsigned acc8[$];
  int unsigned acc4[$];
  bit pv8 = 0, pv4 = 0;
  bit gap_on8 = 0, gap_on4 = 0;
  int unsigned last8 = 0, last4 = 0;

  always @(negedge clk) begin
    if (rst) begin
      q8.delete(); acc8.delete(); pv8 = 0; last8 = 0;
    end else begin
      if (b8.in_valid && b8.in_ready) begin
        q8.push_back(ref_mult(8, 64'(b8.in_a), 64'(b8.in_b), b8.in_signed));
        acc8.push_back(cyc + 1);
        if (gap_on8 && last8 != 0) check("gap8", 64'(cyc + 1 - last8), 64'd10);
        last8 = cyc + 1;
      end
      if (b8.out_valid && !pv8) begin
        if (acc8.size() == 0) fail("lat8 output without accept");
        else check("lat8", 64'(cyc - acc8.pop_front()), 64'd8);
      end
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) fail("prod8 unexpected output");
        else check("prod8", 64'(b8.out_p), q8.pop_front());
      end
      pv8 = b8.out_valid;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q4.delete(); acc4.delete(); pv4 = 0; last4 = 0;
    end else begin
      if (b4.in_valid && b4.in_ready) begin
        q4.push_back(ref_mult(4, 64'(b4.in_a), 64'(b4.in_b), b4.in_signed));
        acc4.push_back(cyc + 1);
        if (gap_on4 && last4 != 0) check("gap4", 64'(cyc + 1 - last4), 64'd6);
        last4 = cyc + 1;
      end
      if (b4.out_valid && !pv4) begin
        if (acc4.size() == 0) fail("lat4 output without accept");
        else check("lat4", 64'(cyc - acc4.pop_front()), 64'd4);
      end
      if (b4.out_valid && b4.out_ready) begin
        if (q4.size() == 0) fail("prod4 unexpected output");
        else check("prod4", 64'(b4.out_p), q4.pop_front());
      end
      pv4 = b4.out_valid;
    end
  end

  task automatic send8(logic [7:0] a, logic [7:0] b, logic s);
    b8.in_a = a; b8.in_b = b; b8.in_signed = s; b8.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b8.in_ready) break;
    end
    if (!b8.in_ready) fail("send8 accept timeout");
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
  endtask

  task automatic send4(logic [3:0] a, logic [3:0] b, logic s);
    b4.in_a = a; b4.in_b = b; b4.in_signed = s; b4.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b4.in_ready) break;
    end
    if (!b4.in_ready) fail("send4 accept timeout");
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q8.size() == 0 && q4.size() == 0 && b8.in_ready && b4.in_ready) begin
        done = 1;
        break;
      end
    end
    if (!done) fail("drain timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp16;
    bit seen;
    b8.in_valid = 0; b8.in_signed = 0; b8.in_a = '0; b8.in_b = '0; b8.out_ready = 1;
    b4.in_valid = 0; b4.in_signed = 0; b4.in_a = '0; b4.in_b = '0; b4.out_ready = 1;
    #12;
    check("rst8 in_ready",  64'(b8.in_ready), 64'd1);
    check("rst8 out_valid", 64'(b8.out_valid), 64'd0);
    check("rst8 busy",      64'(b8.busy), 64'd0);
    check("rst8 out_p",     64'(b8.out_p), 64'd0);
    check("rst4 in_ready",  64'(b4.in_ready), 64'd1);
    check("rst4 out_valid", 64'(b4.out_valid), 64'd0);
    check("rst4 out_p",     64'(b4.out_p), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // WIDTH=4 directed, then exhaustive in both modes, back-to-back
    gap_on4 = 1;
    send4(4'd13, 4'd11, 1'b0);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          send4(4'(a), 4'(b), 1'(s));
    wait_drain();
    gap_on4 = 0;

    // WIDTH=8 boundaries and random back-to-back pairs
    gap_on8 = 1;
    send8(8'h80, 8'h80, 1'b1);
    send8(8'h80, 8'h7F, 1'b1);
    send8(8'hFF, 8'hFF, 1'b1);
    send8(8'hFF, 8'hFF, 1'b0);
    send8(8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++)
      send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    wait_drain();
    gap_on8 = 0;

    // Backpressure with ignored operands during BUSY and DONE
    b8.out_ready = 0;
    exp16 = 16'(ref_mult(8, 64'd100, 64'hF3, 1'b1));
    send8(8'd100, 8'hF3, 1'b1);
    b8.in_a = 8'd5; b8.in_b = 8'd9; b8.in_signed = 0; b8.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp busy in_ready", 64'({b8.in_ready, b8.busy}), 64'b01);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b8.out_valid) begin seen = 1; break; end
    end
    if (!seen) fail("bp out_valid timeout");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp hold", 64'({b8.in_ready, b8.out_valid, b8.out_p}), 64'({1'b0, 1'b1, exp16}));
    end
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    b8.out_ready = 1;
    send8(8'd3, 8'd4, 1'b0);
    wait_drain();

    // Asynchronous reset mid-BUSY discards the in-flight product
    send8(8'd200, 8'd3, 1'b0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst in_ready",  64'(b8.in_ready), 64'd1);
    check("arst out_valid", 64'(b8.out_valid), 64'd0);
    check("arst busy",      64'(b8.busy), 64'd0);
    check("arst out_p",     64'(b8.out_p), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("arst hold out_valid", 64'(b8.out_valid), 64'd0);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post-rst no out_valid", 64'(b8.out_valid), 64'd0);
    end
    send8(8'd7, 8'd6, 1'b0);
    wait_drain();

    check("q8 drained", 64'(q8.size()), 64'd0);
    check("q4 drained", 64'(q4.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
